// File: rtl/snake_pkg.sv
// Shared encodings for the snake game: directions, the reversal rule and scheduler states.
package snake_pkg;

  localparam logic [1:0] DirUp    = 2'd0;
  localparam logic [1:0] DirRight = 2'd1;
  localparam logic [1:0] DirDown  = 2'd2;
  localparam logic [1:0] DirLeft  = 2'd3;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StRun     = 3'd1;
  localparam logic [2:0] StWaitAck = 3'd2;
  localparam logic [2:0] StPaused  = 3'd3;
  localparam logic [2:0] StOver    = 3'd4;

  // Opposite direction: up<->down, right<->left.
  function automatic logic [1:0] rev_dir(input logic [1:0] d);
    return d ^ 2'd2;
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// Two-entry direction FIFO. Pop is applied before push when both occur in one cycle.
module dir_fifo (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [1:0] data_i,
  output logic [1:0] head_o,
  output logic [1:0] tail_o,
  output logic       empty_o,
  output logic       full_o
);

  logic [1:0] mem0_q, mem0_d;
  logic [1:0] mem1_q, mem1_d;
  logic [1:0] cnt_q, cnt_d;

  // Next-state: clear, then pop (shift), then push into the first free slot.
  always_comb begin
    mem0_d = mem0_q;
    mem1_d = mem1_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      cnt_d = 2'd0;
    end else begin
      if (pop_i && (cnt_q != 2'd0)) begin
        mem0_d = mem1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      if (push_i && (cnt_d != 2'd2)) begin
        if (cnt_d == 2'd0) begin
          mem0_d = data_i;
        end else begin
          mem1_d = data_i;
        end
        cnt_d = cnt_d + 2'd1;
      end
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem0_q <= 2'd0;
      mem1_q <= 2'd0;
      cnt_q  <= 2'd0;
    end else begin
      mem0_q <= mem0_d;
      mem1_q <= mem1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_o  = mem0_q;
  assign tail_o  = (cnt_q == 2'd2) ? mem1_q : mem0_q;
  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);

endmodule

// File: rtl/snake_step_scheduler.sv
// Game-step controller: tick divider, buffered direction changes, step handshake,
// scoring/level-up and game-over handling.
module snake_step_scheduler
  import snake_pkg::*;
#(
  parameter int unsigned BASE_PERIOD    = 6250000,
  parameter int unsigned PERIOD_STEP    = 500000,
  parameter int unsigned MIN_PERIOD     = 2500000,
  parameter int unsigned FOOD_PER_LEVEL = 5,
  parameter int unsigned MAX_LEVEL      = 7,
  parameter int unsigned CNT_W          = 23
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        pause_i,
  input  logic        dir_valid_i,
  input  logic [1:0]  dir_in_i,
  output logic        step_req_o,
  output logic [1:0]  step_dir_o,
  input  logic        step_ack_i,
  input  logic        ate_i,
  input  logic        hit_i,
  output logic        running_o,
  output logic        game_over_o,
  output logic [2:0]  level_o,
  output logic [15:0] score_o,
  output logic        overrun_o
);

  localparam int unsigned FoodW = $clog2(FOOD_PER_LEVEL + 1);

  // Period for a level: BASE - lvl*STEP, floored at MIN without unsigned underflow.
  function automatic logic [CNT_W-1:0] period_for(input logic [2:0] lvl);
    int unsigned red;
    red = 32'(lvl) * PERIOD_STEP;
    if (BASE_PERIOD < MIN_PERIOD + red) return CNT_W'(MIN_PERIOD);
    return CNT_W'(BASE_PERIOD - red);
  endfunction

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [1:0]       cur_dir_q, cur_dir_d;
  logic             step_req_q, step_req_d;
  logic [2:0]       level_q, level_d;
  logic [15:0]      score_q, score_d;
  logic [FoodW-1:0] food_cnt_q, food_cnt_d;
  logic             overrun_q, overrun_d;

  logic       fifo_clear, fifo_push, fifo_pop;
  logic       fifo_empty, fifo_full;
  logic [1:0] fifo_head, fifo_tail, ref_dir;
  logic       active, counting, tick;

  assign active   = (state_q == StRun) || (state_q == StWaitAck) || (state_q == StPaused);
  assign counting = (state_q == StRun) || (state_q == StWaitAck);
  assign tick     = counting && (count_q == period_q - CNT_W'(1));
  // A pop never changes the reference: the popped head is the old tail when only one is queued.
  assign ref_dir  = fifo_empty ? cur_dir_q : fifo_tail;

  // Next-state: divider, game FSM, scoring and direction filtering.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    period_d   = period_q;
    cur_dir_d  = cur_dir_q;
    step_req_d = step_req_q;
    level_d    = level_q;
    score_d    = score_q;
    food_cnt_d = food_cnt_q;
    overrun_d  = overrun_q;
    fifo_clear = 1'b0;
    fifo_pop   = 1'b0;

    if (counting) begin
      if (tick) begin
        count_d  = '0;
        period_d = period_for(level_q);
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end

    case (state_q)
      StIdle, StOver: begin
        if (start_i) begin
          state_d    = StRun;
          count_d    = '0;
          period_d   = CNT_W'(BASE_PERIOD);
          cur_dir_d  = DirRight;
          level_d    = 3'd0;
          score_d    = 16'd0;
          food_cnt_d = '0;
          overrun_d  = 1'b0;
          fifo_clear = 1'b1;
        end
      end
      StRun: begin
        if (tick) begin
          fifo_pop   = !fifo_empty;
          if (!fifo_empty) cur_dir_d = fifo_head;
          step_req_d = 1'b1;
          state_d    = StWaitAck;
        end else if (pause_i) begin
          state_d = StPaused;
        end
      end
      StWaitAck: begin
        if (tick) overrun_d = 1'b1;
        if (step_ack_i) begin
          step_req_d = 1'b0;
          if (hit_i) begin
            state_d = StOver;
          end else begin
            if (ate_i) begin
              if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
              if (food_cnt_q == FoodW'(FOOD_PER_LEVEL - 1)) begin
                food_cnt_d = '0;
                if (level_q != 3'(MAX_LEVEL)) level_d = level_q + 3'd1;
              end else begin
                food_cnt_d = food_cnt_q + FoodW'(1);
              end
            end
            state_d = pause_i ? StPaused : StRun;
          end
        end
      end
      StPaused: begin
        if (!pause_i) state_d = StRun;
      end
      default: state_d = StIdle;
    endcase

    fifo_push = dir_valid_i && active && (!fifo_full || fifo_pop) &&
                (dir_in_i != ref_dir) && (dir_in_i != rev_dir(ref_dir));
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      count_q    <= '0;
      period_q   <= CNT_W'(BASE_PERIOD);
      cur_dir_q  <= DirRight;
      step_req_q <= 1'b0;
      level_q    <= 3'd0;
      score_q    <= 16'd0;
      food_cnt_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      period_q   <= period_d;
      cur_dir_q  <= cur_dir_d;
      step_req_q <= step_req_d;
      level_q    <= level_d;
      score_q    <= score_d;
      food_cnt_q <= food_cnt_d;
      overrun_q  <= overrun_d;
    end
  end

  dir_fifo u_dir_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (fifo_clear),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (dir_in_i),
    .head_o  (fifo_head),
    .tail_o  (fifo_tail),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign step_req_o  = step_req_q;
  assign step_dir_o  = cur_dir_q;
  assign running_o   = active;
  assign game_over_o = (state_q == StOver);
  assign level_o     = level_q;
  assign score_o     = score_q;
  assign overrun_o   = overrun_q;

endmodule
